vga_frame_writer: RTL

Write-side companion to the VGA frame reader. Accepts a raster-ordered 24-bit pixel stream with a valid/ready handshake and a start-of-frame marker, and drives the write port of the frame buffer RAM. The reader scans that RAM by address. Also provides a hardware fill that clears the whole frame to one colour. Sits between any pixel source (test pattern, CPU bridge) and the frame RAM write port; address map is linear, address = y*H_ACTIVE + x.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_raster_counter.sv | 60 ++++++
 rtl/vga_frame_writer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame constants and writer state encoding
package vga_pkg;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int ADDR_W_DEF       = 20;
  localparam int PIXEL_W_DEF      = 24;
  localparam int FRAME_PIXELS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FILL   = 2'd2
  } writer_state_t;

  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// rtl/vga_raster_counter.sv - raster x/y and linear address counter with last-pixel flag
module vga_raster_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int XW       = $clog2(H_ACTIVE + 1),
  parameter int YW       = $clog2(V_ACTIVE + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [ADDR_W-1:0] address,
  output logic              last
);

  logic [XW-1:0]     base_x, next_x;
  logic [YW-1:0]     base_y, next_y;
  logic [ADDR_W-1:0] base_a, next_a;
  logic              base_last;

  // clear and enable together step to the pixel just after (0,0)
  always_comb begin
    base_x    = clear ? '0 : x;
    base_y    = clear ? '0 : y;
    base_a    = clear ? '0 : address;
    base_last = (base_x == XW'(H_ACTIVE - 1)) && (base_y == YW'(V_ACTIVE - 1));
    next_x    = base_x;
    next_y    = base_y;
    next_a    = base_a;
    if (enable) begin
      if (base_x == XW'(H_ACTIVE - 1)) begin
        next_x = '0;
        next_y = (base_y == YW'(V_ACTIVE - 1)) ? '0 : base_y + YW'(1);
      end else begin
        next_x = base_x + XW'(1);
      end
      next_a = base_last ? '0 : base_a + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      address <= '0;
    end else begin
      x       <= next_x;
      y       <= next_y;
      address <= next_a;
    end
  end

  assign last = (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - pixel stream and solid-fill writer for the frame buffer RAM
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIXEL_W  = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  input  logic               fill_start,
  input  logic [PIXEL_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]  write_address,
  output logic [PIXEL_W-1:0] write_data,
  output logic               write_enable,
  output logic               busy,
  output logic               frame_done,
  output logic               sof_error
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  writer_state_t      state, state_d;
  logic               accept;
  logic               cnt_clear, cnt_enable, cnt_last;
  logic [XW-1:0]      cnt_x;
  logic [YW-1:0]      cnt_y;
  logic [ADDR_W-1:0]  cnt_address;
  logic               we_d, done_d, err_d, latch_fill;
  logic [ADDR_W-1:0]  addr_d;
  logic [PIXEL_W-1:0] data_d, fill_q;
  logic               unused_xy;

  assign accept    = in_valid && in_ready;
  assign unused_xy = ^{cnt_x, cnt_y};

  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W),
    .XW       (XW),
    .YW       (YW)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .x       (cnt_x),
    .y       (cnt_y),
    .address (cnt_address),
    .last    (cnt_last)
  );

  always_comb begin
    state_d    = state;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    we_d       = 1'b0;
    addr_d     = cnt_address;
    data_d     = in_pixel;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch_fill = 1'b0;
    case (state)
      ST_IDLE: begin
        // a sof beat outranks a simultaneous fill request
        if (accept && in_sof) begin
          cnt_clear  = 1'b1;
          cnt_enable = 1'b1;
          we_d       = 1'b1;
          addr_d     = '0;
          state_d    = ST_STREAM;
        end else begin
          err_d = accept;
          if (fill_start) begin
            latch_fill = 1'b1;
            cnt_clear  = 1'b1;
            state_d    = ST_FILL;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          we_d       = 1'b1;
          cnt_enable = 1'b1;
          if (in_sof) begin
            err_d     = 1'b1;
            cnt_clear = 1'b1;
            addr_d    = '0;
          end else if (cnt_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FILL: begin
        we_d       = 1'b1;
        data_d     = fill_q;
        cnt_enable = 1'b1;
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      frame_done    <= 1'b0;
      sof_error     <= 1'b0;
      fill_q        <= '0;
    end else begin
      in_ready      <= (state_d != ST_FILL);
      write_enable  <= we_d;
      write_address <= addr_d;
      write_data    <= data_d;
      frame_done    <= done_d;
      sof_error     <= err_d;
      if (latch_fill) fill_q <= fill_colour;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
